// File: rtl/dino_motion_controller.sv
`default_nettype none
// ============================================================================
// Module : dino_motion_controller
// Frame-rate jump physics for the dino sprite: frame tick, jump FSM, score.
// Rev    : 1.0  initial release
// ============================================================================
module dino_motion_controller #(
  parameter int X_POS     = 100,
  parameter int GROUND_Y  = 400,
  parameter int TOP_LIMIT = 60,
  parameter int JUMP_VEL  = 16,
  parameter int GRAVITY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_ready,
  input  logic        jump_btn,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic        jumping,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_GROUND = 2'd1,
    ST_AIR    = 2'd2
  } state_t;

  localparam logic signed [12:0] GROUND_Y13  = 13'(GROUND_Y);
  localparam logic signed [13:0] GROUND_Y14  = 14'(GROUND_Y);
  localparam logic signed [12:0] TOP_LIMIT13 = 13'(TOP_LIMIT);
  localparam logic signed [13:0] TOP_LIMIT14 = 14'(TOP_LIMIT);
  localparam logic signed [7:0]  JUMP_VEL8   = 8'(JUMP_VEL);
  localparam logic signed [7:0]  GRAVITY8    = 8'(GRAVITY);

  state_t             state;
  logic               btn_meta;
  logic               btn_sync;
  logic               btn_prev;
  logic               sr_q;
  logic               sr_prev;
  logic               jump_req;
  logic signed [12:0] y;
  logic signed [7:0]  vy;

  logic               frame_tick;
  logic               btn_rise;
  logic signed [13:0] y_next;
  logic signed [7:0]  vy_next;

  assign frame_tick = sr_q & ~sr_prev;
  assign btn_rise   = btn_sync & ~btn_prev;
  // One extra bit of headroom so a large upward step cannot wrap past the limits.
  assign y_next     = {y[12], y} - {{6{vy[7]}}, vy};
  assign vy_next    = vy - GRAVITY8;

  assign x_coor = 32'(X_POS);
  assign y_coor = {20'd0, y[11:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
      sr_q     <= 1'b0;
      sr_prev  <= 1'b0;
    end else begin
      btn_meta <= jump_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      sr_q     <= screen_ready;
      sr_prev  <= sr_q;
    end
  end

  // A fresh edge wins over the tick clear, so it is served on the following tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jump_req <= 1'b0;
    end else if (btn_rise) begin
      jump_req <= 1'b1;
    end else if (frame_tick) begin
      jump_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_WAIT;
      y       <= GROUND_Y13;
      vy      <= '0;
      score   <= '0;
      jumping <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        ST_WAIT: begin
          if (jump_req) begin
            state <= ST_GROUND;
          end
        end
        ST_GROUND: begin
          if (score != 16'hFFFF) begin
            score <= score + 16'd1;
          end
          if (jump_req) begin
            vy      <= JUMP_VEL8;
            state   <= ST_AIR;
            jumping <= 1'b1;
          end
        end
        ST_AIR: begin
          if (score != 16'hFFFF) begin
            score <= score + 16'd1;
          end
          if (y_next >= GROUND_Y14) begin
            y       <= GROUND_Y13;
            vy      <= '0;
            state   <= ST_GROUND;
            jumping <= 1'b0;
          end else if (y_next < TOP_LIMIT14) begin
            y  <= TOP_LIMIT13;
            vy <= vy_next;
          end else begin
            y  <= y_next[12:0];
            vy <= vy_next;
          end
        end
        default: begin
          state   <= ST_WAIT;
          jumping <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dino_motion_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_dino_motion_controller
// Directed bench for two controller instances (JUMP_VEL 16 and 40) vs a frame model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dino_motion_controller;

  logic        clk;
  logic        reset;
  logic        screen_ready;
  logic        jump_btn;
  logic [31:0] x16, y16, x40, y40;
  logic        j16, j40;
  logic [15:0] s16, s40;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level model: 0 = WAIT, 1 = GROUND, 2 = AIR
  int m_state [2];
  int m_y     [2];
  int m_vy    [2];
  int m_score [2];
  bit m_req;

  dino_motion_controller #(.JUMP_VEL(16)) dut16 (
    .clk(clk), .reset(reset), .screen_ready(screen_ready), .jump_btn(jump_btn),
    .x_coor(x16), .y_coor(y16), .jumping(j16), .score(s16)
  );

  dino_motion_controller #(.JUMP_VEL(40)) dut40 (
    .clk(clk), .reset(reset), .screen_ready(screen_ready), .jump_btn(jump_btn),
    .x_coor(x40), .y_coor(y40), .jumping(j40), .score(s40)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int jv(input int i);
    return (i == 0) ? 16 : 40;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_y[i]     = 400;
      m_vy[i]    = 0;
      m_score[i] = 0;
    end
    m_req = 1'b0;
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      int yn;
      case (m_state[i])
        0: if (m_req) m_state[i] = 1;
        1: begin
          if (m_score[i] < 65535) m_score[i]++;
          if (m_req) begin
            m_vy[i]    = jv(i);
            m_state[i] = 2;
          end
        end
        default: begin
          if (m_score[i] < 65535) m_score[i]++;
          yn = m_y[i] - m_vy[i];
          if (yn >= 400) begin
            m_y[i]     = 400;
            m_vy[i]    = 0;
            m_state[i] = 1;
          end else begin
            m_y[i]  = (yn < 60) ? 60 : yn;
            m_vy[i] = m_vy[i] - 1;
          end
        end
      endcase
    end
    m_req = 1'b0;
  endtask

  // screen_ready high for 4 clocks; DUT state changes on the second rising edge.
  task automatic frame();
    @(negedge clk); screen_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1 model_tick();
    repeat (3) @(negedge clk);
    screen_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk); jump_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_req = 1'b1;
    @(negedge clk); jump_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Synchronized button edge lands on the same clock as the frame tick.
  task automatic press_with_tick();
    @(negedge clk); jump_btn = 1'b1;
    @(negedge clk); screen_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 model_tick();
    m_req = 1'b1;
    repeat (3) @(negedge clk);
    screen_ready = 1'b0;
    jump_btn     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("x_coor dut%0d t=%0t", i, $time), (i == 0) ? x16 : x40, 32'd100);
      check($sformatf("y_coor dut%0d t=%0t", i, $time), (i == 0) ? y16 : y40, 32'(m_y[i] & 'hFFF));
      check($sformatf("jumping dut%0d t=%0t", i, $time), {31'd0, (i == 0) ? j16 : j40},
            32'(m_state[i] == 2));
      check($sformatf("score dut%0d t=%0t", i, $time), {16'd0, (i == 0) ? s16 : s40},
            32'(m_score[i]));
    end
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bench timeout");
  end

  initial begin
    reset        = 1'b0;
    screen_ready = 1'b0;
    jump_btn     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;

    check("reset x16", x16, 32'd100);
    check("reset y16", y16, 32'd400);
    check("reset score16", {16'd0, s16}, 32'd0);
    check("reset jumping16", {31'd0, j16}, 32'd0);

    repeat (3) frame();
    check("idle y16", y16, 32'd400);
    check("idle score16", {16'd0, s16}, 32'd0);
    check("idle jumping16", {31'd0, j16}, 32'd0);

    press(); frame();
    check("wait->ground jumping", {31'd0, j16}, 32'd0);
    check("wait tick score", {16'd0, s16}, 32'd0);
    press(); frame();
    check("takeoff jumping16", {31'd0, j16}, 32'd1);
    check("takeoff jumping40", {31'd0, j40}, 32'd1);
    check("takeoff score16", {16'd0, s16}, 32'd1);
    frame();
    check("air1 y16", y16, 32'd384);
    check("air1 y40", y40, 32'd360);
    check("air1 score16", {16'd0, s16}, 32'd2);

    for (int t = 2; t <= 67; t++) begin
      frame();
      case (t)
        10: check("air10 y40 clamped", y40, 32'd60);
        16: check("air16 y16", y16, 32'd264);
        17: check("air17 y16", y16, 32'd264);
        18: check("air18 y16", y16, 32'd265);
        30: check("air30 y40 clamped", y40, 32'd60);
        33: begin
          check("air33 y16 landed", y16, 32'd400);
          check("air33 jumping16", {31'd0, j16}, 32'd0);
        end
        34: check("no double jump", {31'd0, j16}, 32'd0);
        66: check("air66 y40", y40, 32'd385);
        67: begin
          check("air67 y40 landed", y40, 32'd400);
          check("air67 jumping40", {31'd0, j40}, 32'd0);
        end
        default: ;
      endcase
      if (t == 20) press();
    end
    check("model pin dut16 ground", 32'(m_state[0]), 32'd1);

    press_with_tick();
    check("coincident tick stays ground", {31'd0, j16}, 32'd0);
    frame();
    check("coincident served next tick", {31'd0, j16}, 32'd1);
    check("coincident served next tick 40", {31'd0, j40}, 32'd1);

    repeat (10) frame();
    @(posedge clk); #2 reset = 1'b0;
    model_reset();
    #1;
    check("midjump reset y16", y16, 32'd400);
    check("midjump reset jumping16", {31'd0, j16}, 32'd0);
    check("midjump reset score16", {16'd0, s16}, 32'd0);
    check("midjump reset y40", y40, 32'd400);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;

    frame();
    check("post reset y16", y16, 32'd400);
    check("post reset jumping16", {31'd0, j16}, 32'd0);
    press(); frame();
    press(); frame();
    frame();
    check("post reset fresh jump y16", y16, 32'd384);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dino_motion_controller.md
DINO_MOTION_CONTROLLER -- requirements
Module: dino_motion_controller

Interface
REQ-001 The block SHALL take parameter X_POS, default 100, meaning fixed sprite center x in pixels.
REQ-002 The block SHALL take parameter GROUND_Y, default 400, meaning sprite bottom y when grounded.
REQ-003 The block SHALL take parameter TOP_LIMIT, default 60, meaning minimum allowed sprite bottom y, which keeps the sprite top at or above 0.
REQ-004 The block SHALL take parameter JUMP_VEL, default 16, meaning initial upward velocity in pixels/frame.
REQ-005 The block SHALL take parameter GRAVITY, default 1, meaning velocity decrement per frame.
REQ-006 The block SHALL have port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-008 The block SHALL have port screen_ready, input, 1 bit: frame-end strobe from the VGA controller, high for several clk cycles.
REQ-009 The block SHALL have port jump_btn, input, 1 bit: asynchronous, debounced jump button (1 = pressed).
REQ-010 The block SHALL have port x_coor, output, 32 bits: sprite center x to the VGA controller.
REQ-011 The block SHALL have port y_coor, output, 32 bits: sprite bottom y to the VGA controller.
REQ-012 The block SHALL have port jumping, output, 1 bit: high while the state is AIR.
REQ-013 The block SHALL have port score, output, 16 bits: count of frames elapsed in GROUND or AIR.

Function
REQ-014 jump_btn SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL set a jump_req flag.
REQ-015 frame_tick SHALL be a one-clk pulse on the first clk cycle in which registered screen_ready is 1 and its previous sample is 0 (exactly one tick per frame).
REQ-016 All position, velocity, state and score updates SHALL occur only in the clk cycle on which frame_tick is 1; outputs SHALL reflect the update one clk cycle later (registered).
REQ-017 States SHALL be WAIT, GROUND and AIR.
REQ-018 WAIT: on a tick with jump_req=1 the block SHALL go to GROUND, clear jump_req, and leave y unchanged.
REQ-019 GROUND: on a tick with jump_req=1 the block SHALL load vy=JUMP_VEL, go to AIR, and apply the first AIR update on the next tick.
REQ-020 AIR, per tick: the block SHALL compute y_next = y - vy and vy_next = vy - GRAVITY; if y_next >= GROUND_Y it SHALL set y=GROUND_Y and vy=0 and go to GROUND.
REQ-021 AIR, per tick: if y_next < TOP_LIMIT the block SHALL set y=TOP_LIMIT and still apply vy_next.
REQ-022 Arithmetic: y SHALL be a signed 13-bit value and vy a signed 8-bit value; the comparisons in REQ-020 and REQ-021 SHALL be signed.
REQ-023 jump_req SHALL be cleared on every tick regardless of state; presses during AIR SHALL be discarded, with no buffered double jump.
REQ-024 If a button edge and a tick coincide, the edge SHALL set jump_req after the tick clear, so the request is served on the next tick.
REQ-025 x_coor SHALL equal X_POS zero-extended; y_coor SHALL equal y[11:0] zero-extended to 32 bits.
REQ-026 score SHALL increment by 1 per tick in GROUND or AIR, SHALL saturate at 16'hFFFF, and SHALL hold in WAIT.

Reset
REQ-027 When reset=0, the block SHALL immediately force state=WAIT, y=GROUND_Y, vy=0, jump_req=0, score=0, jumping=0, y_coor=GROUND_Y, x_coor=X_POS, and clear the synchronizer and edge-detect flops.
REQ-028 A reset asserted mid-jump SHALL return the sprite to GROUND_Y in WAIT with no residual velocity after release.

Verification
REQ-029 Reset then 3 ticks without a press SHALL yield state WAIT, y_coor=400, score=0.
REQ-030 Press, tick, press, tick (defaults) SHALL give GROUND after tick 1; after tick 2 jumping=1 and vy=16; after tick 3 y_coor=384.
REQ-031 A full jump (defaults) SHALL produce y_coor=264 after AIR tick 16, 264 after AIR tick 17, and 400 with jumping=0 after AIR tick 33.
REQ-032 A jump with JUMP_VEL=40 SHALL hold y_coor at 60 while clamped, then descend, and land at exactly 400.
REQ-033 A press during AIR SHALL cause no second jump, with GROUND reached on schedule; a press coincident with a tick in GROUND SHALL start AIR one tick later.
REQ-034 screen_ready held high for 4 clk cycles per frame SHALL produce exactly one tick; reset asserted at AIR tick 10 SHALL give y_coor=400, jumping=0 and score=0 immediately.
